// File: rtl/nn_pkg.sv
// Shared types and helpers for the sequential neural-network datapath blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_BIAS  = 2'd2,
    ST_STORE = 2'd3
  } dense_state_e;

  // Container width for the post-accumulation shaping stages; accumulators are narrower.
  localparam int WIDE_W = 32;

  function automatic int clog2_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic logic signed [WIDE_W-1:0] relu(input logic signed [WIDE_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_signed(input logic signed [WIDE_W-1:0] x,
                                                         input int bits);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One MAC lane: accumulates act*weight over a neuron, adds its bias, then
// shapes the result with optional ReLU and saturation to the output width.
module dense_mac_lane
  import nn_pkg::*;
#(
  parameter int A_BITS = 2,
  parameter int W_BITS = 2,
  parameter int B_BITS = 4,
  parameter int O_BITS = 6,
  parameter int ACC_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     mac_en,
  input  logic                     bias_en,
  input  logic                     relu_en,
  input  logic signed [A_BITS-1:0] act,
  input  logic signed [W_BITS-1:0] weight,
  input  logic signed [B_BITS-1:0] bias,
  output logic [O_BITS-1:0]        result
);

  localparam int P_W = A_BITS + W_BITS;

  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [WIDE_W-1:0] acc_wide;
  logic signed [WIDE_W-1:0] shaped;

  assign prod = act * weight;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end else if (bias_en) begin
      acc_d = acc_q + ACC_W'(bias);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The accumulator is sized never to wrap; only the shaped output clips.
  always_comb begin
    acc_wide = WIDE_W'(acc_q);
    shaped   = relu_en ? relu(acc_wide) : acc_wide;
    result   = O_BITS'(sat_signed(shaped, O_BITS));
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: LANES neurons per group, weights and
// biases from an external ROM. Define DENSE_ARGMAX_EN to add the running argmax.
module dense_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN   = 48,
  parameter int N_OUT  = 10,
  parameter int LANES  = 1,
  parameter int A_BITS = 2,
  parameter int W_BITS = 2,
  parameter int B_BITS = 4,
  parameter int O_BITS = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic                                     relu_en,
  input  logic [N_IN*A_BITS-1:0]                   act_flat,
  output logic [clog2_w(N_OUT/LANES*N_IN)-1:0]     w_addr,
  input  logic [LANES*W_BITS-1:0]                  w_data,
  output logic [clog2_w(N_OUT/LANES)-1:0]          b_addr,
  input  logic [LANES*B_BITS-1:0]                  b_data,
  output logic                                     busy,
  output logic                                     done,
  input  logic [clog2_w(N_OUT)-1:0]                rd_addr,
  output logic [O_BITS-1:0]                        rd_data,
  output logic [clog2_w(N_OUT)-1:0]                max_idx,
  output logic [O_BITS-1:0]                        max_val
);

  localparam int G     = N_OUT / LANES;
  localparam int WA_W  = clog2_w(G * N_IN);
  localparam int BA_W  = clog2_w(G);
  localparam int RA_W  = clog2_w(N_OUT);
  localparam int MI_W  = clog2_w(N_IN);
  localparam int ACC_W = A_BITS + W_BITS + $clog2(N_IN) + 1;

  dense_state_e            state_q, state_d;
  logic [BA_W-1:0]         group_q, group_d;
  logic [MI_W-1:0]         mac_idx_q, mac_idx_d;
  logic [N_IN*A_BITS-1:0]  act_q, act_d;
  logic                    relu_q, relu_d;
  logic [O_BITS-1:0]       out_mem_q [N_OUT];
  logic [O_BITS-1:0]       out_mem_d [N_OUT];
  logic [O_BITS-1:0]       lane_res  [LANES];
  logic [A_BITS-1:0]       act_sel;
  logic                    start_acc;
  logic                    store_en;
  logic                    last_mac;
  logic                    last_group;

  assign last_mac   = (mac_idx_q == MI_W'(N_IN - 1));
  assign last_group = (group_q == BA_W'(G - 1));
  assign act_sel    = act_q[mac_idx_q * A_BITS +: A_BITS];
  assign w_addr     = WA_W'(group_q) * WA_W'(N_IN) + WA_W'(mac_idx_q);
  assign b_addr     = group_q;
  assign busy       = (state_q != ST_IDLE) && !done;
  assign rd_data    = (int'(rd_addr) < N_OUT) ? out_mem_q[rd_addr] : '0;

  // Counters return to zero whenever the engine goes idle so the ROM ports rest at 0.
  always_comb begin
    state_d   = state_q;
    group_d   = group_q;
    mac_idx_d = mac_idx_q;
    act_d     = act_q;
    relu_d    = relu_q;
    start_acc = 1'b0;
    store_en  = 1'b0;
    done      = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      group_d   = '0;
      mac_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            act_d     = act_flat;
            relu_d    = relu_en;
            group_d   = '0;
            mac_idx_d = '0;
            start_acc = 1'b1;
            state_d   = ST_MAC;
          end
        end
        ST_MAC: begin
          if (last_mac) begin
            mac_idx_d = '0;
            state_d   = ST_BIAS;
          end else begin
            mac_idx_d = mac_idx_q + 1'b1;
          end
        end
        ST_BIAS: state_d = ST_STORE;
        ST_STORE: begin
          store_en = 1'b1;
          if (last_group) begin
            done    = 1'b1;
            group_d = '0;
            state_d = ST_IDLE;
          end else begin
            group_d = group_q + 1'b1;
            state_d = ST_MAC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(
      .A_BITS(A_BITS),
      .W_BITS(W_BITS),
      .B_BITS(B_BITS),
      .O_BITS(O_BITS),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_acc || (state_q == ST_STORE)),
      .mac_en (state_q == ST_MAC),
      .bias_en(state_q == ST_BIAS),
      .relu_en(relu_q),
      .act    (act_sel),
      .weight (w_data[l*W_BITS +: W_BITS]),
      .bias   (b_data[l*B_BITS +: B_BITS]),
      .result (lane_res[l])
    );
  end

  always_comb begin
    out_mem_d = out_mem_q;
    if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        out_mem_d[RA_W'(int'(group_q) * LANES + l)] = lane_res[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      group_q   <= '0;
      mac_idx_q <= '0;
      act_q     <= '0;
      relu_q    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) out_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      mac_idx_q <= mac_idx_d;
      act_q     <= act_d;
      relu_q    <= relu_d;
      out_mem_q <= out_mem_d;
    end
  end

`ifdef DENSE_ARGMAX_EN
  logic [RA_W-1:0]   max_idx_q, max_idx_d;
  logic [O_BITS-1:0] max_val_q, max_val_d;

  // Lane 0 of group 0 seeds the max; strict compare keeps the lowest index on ties.
  always_comb begin
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (((group_q == '0) && (l == 0)) ||
            ($signed(lane_res[l]) > $signed(max_val_d))) begin
          max_val_d = lane_res[l];
          max_idx_d = RA_W'(int'(group_q) * LANES + l);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign max_idx = max_idx_q;
  assign max_val = max_val_q;
`else
  assign max_idx = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: default 48->10 single-lane instance (a)
// and a two-lane instance (b), with behavioural ROMs and hand-computed results.
`timescale 1ns/1ps
module tb_dense_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_mem [10];

  // Instance a: default parameters.
  logic        start_a, abort_a, relu_a;
  logic [95:0] act_a;
  logic [8:0]  w_addr_a;
  logic [1:0]  w_data_a;
  logic [3:0]  b_addr_a;
  logic [3:0]  b_data_a;
  logic        busy_a, done_a;
  logic [3:0]  rd_addr_a;
  logic [5:0]  rd_data_a;
  logic [3:0]  max_idx_a;
  logic [5:0]  max_val_a;

  int          wmode;
  logic [1:0]  wconst;
  logic [3:0]  btab [10];

  always_comb begin
    if (wmode == 1)
      w_data_a = ((int'(w_addr_a) % 48) < (int'(w_addr_a) / 48) * 3) ? 2'b01 : 2'b00;
    else
      w_data_a = wconst;
    b_data_a = (int'(b_addr_a) < 10) ? btab[b_addr_a] : 4'b0000;
  end

  dense_layer_seq dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .relu_en(relu_a),
    .act_flat(act_a), .w_addr(w_addr_a), .w_data(w_data_a), .b_addr(b_addr_a),
    .b_data(b_data_a), .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .max_idx(max_idx_a), .max_val(max_val_a)
  );

  // Instance b: two lanes, zero weights, bias of neuron k is k-5.
  logic        start_b, abort_b, relu_b;
  logic [95:0] act_b;
  logic [7:0]  w_addr_b;
  logic [3:0]  w_data_b;
  logic [2:0]  b_addr_b;
  logic [7:0]  b_data_b;
  logic        busy_b, done_b;
  logic [3:0]  rd_addr_b;
  logic [5:0]  rd_data_b;
  logic [3:0]  max_idx_b;
  logic [5:0]  max_val_b;

  assign w_data_b = 4'b0000;
  assign b_data_b = {4'(2 * int'(b_addr_b) - 4), 4'(2 * int'(b_addr_b) - 5)};

  dense_layer_seq #(.N_IN(48), .N_OUT(10), .LANES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .relu_en(relu_b),
    .act_flat(act_b), .w_addr(w_addr_b), .w_data(w_data_b), .b_addr(b_addr_b),
    .b_data(b_data_b), .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .max_idx(max_idx_b), .max_val(max_val_b)
  );

  task automatic set_act_all(input logic [1:0] v);
    for (int i = 0; i < 48; i++) act_a[i*2 +: 2] = v;
  endtask

  task automatic set_btab_all(input logic [3:0] v);
    for (int k = 0; k < 10; k++) btab[k] = v;
  endtask

  task automatic kick_a(input logic relu);
    relu_a  = relu;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int cur, input int exp_cyc, input string tag);
    int cyc;
    bit seen;
    cyc  = cur;
    seen = 1'b0;
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_during_run: got %b expected 1", tag, busy_a);
    end
    while (cyc < 2000) begin
      if (done_a === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!seen || cyc != exp_cyc) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, seen ? cyc : -1, exp_cyc);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b expected 0", tag, busy_a);
    end
    @(posedge clk); #1;
    total++;
    if (done_a !== 1'b0) begin
      bad++;
      $display("FAIL %s done_one_cycle: got %b expected 0", tag, done_a);
    end
  endtask

  task automatic check_mem_a(input string tag);
    for (int k = 0; k < 10; k++) begin
      rd_addr_a = 4'(k);
      #1;
      total++;
      if (rd_data_a !== 6'(exp_mem[k])) begin
        bad++;
        $display("FAIL %s out[%0d]: got %0d expected %0d", tag, k, $signed(rd_data_a), exp_mem[k]);
      end
    end
    rd_addr_a = 4'd12;
    #1;
    total++;
    if (rd_data_a !== 6'd0) begin
      bad++;
      $display("FAIL %s out_of_range_read: got %0d expected 0", tag, $signed(rd_data_a));
    end
    rd_addr_a = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; relu_a = 1'b0; act_a = '0; rd_addr_a = '0;
    start_b = 1'b0; abort_b = 1'b0; relu_b = 1'b0; act_b = '0; rd_addr_b = '0;
    wmode = 0; wconst = 2'b00;
    set_btab_all(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin
      bad++;
      $display("FAIL reset busy_done: got %b expected 0000", {busy_a, done_a, busy_b, done_b});
    end
    total++;
    if (w_addr_a !== 9'd0 || b_addr_a !== 4'd0) begin
      bad++;
      $display("FAIL reset rom_addr: got w=%0d b=%0d expected 0 0", w_addr_a, b_addr_a);
    end
    total++;
    if (max_idx_a !== 4'd0 || max_val_a !== 6'd0) begin
      bad++;
      $display("FAIL reset argmax: got idx=%0d val=%0d expected 0 0", max_idx_a, max_val_a);
    end
    rd_addr_a = 4'd5;
    #1;
    total++;
    if (rd_data_a !== 6'd0) begin
      bad++;
      $display("FAIL reset out_mem: got %0d expected 0", rd_data_a);
    end
    rd_addr_a = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate_pos();
    set_act_all(2'b01);
    wmode = 0; wconst = 2'b01;
    set_btab_all(4'b0000);
    kick_a(1'b0);
    wait_done_a(1, 500, "sat_pos");
    for (int k = 0; k < 10; k++) exp_mem[k] = 31;
    check_mem_a("sat_pos");
  endtask

  task automatic test_saturate_neg_relu();
    set_act_all(2'b11);
    wconst = 2'b01;
    set_btab_all(4'b1000);
    kick_a(1'b0);
    wait_done_a(1, 500, "sat_neg");
    for (int k = 0; k < 10; k++) exp_mem[k] = -32;
    check_mem_a("sat_neg");
    kick_a(1'b1);
    wait_done_a(1, 500, "relu");
    for (int k = 0; k < 10; k++) exp_mem[k] = 0;
    check_mem_a("relu");
  endtask

  task automatic test_abort_restart();
    bit seen;
    seen = 1'b0;
    set_act_all(2'b01);
    wconst = 2'b01;
    set_btab_all(4'b0000);
    kick_a(1'b0);
    for (int c = 1; c < 120; c++) begin
      if (done_a === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    total++;
    if (seen || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL abort state: got done_seen=%b busy=%b expected 0 0", seen, busy_a);
    end
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (j == 3) ? 9 : j;
      rd_addr_a = 4'(k);
      #1;
      total++;
      if (rd_data_a !== ((k < 2) ? 6'd31 : 6'd0)) begin
        bad++;
        $display("FAIL abort out[%0d]: got %0d expected %0d", k, $signed(rd_data_a), (k < 2) ? 31 : 0);
      end
    end
    // Restart right away; activations change after start and must not matter.
    set_act_all(2'b00);
    for (int i = 0; i < 10; i++) act_a[i*2 +: 2] = 2'b01;
    kick_a(1'b0);
    set_act_all(2'b11);
    for (int c = 1; c < 30; c++) begin
      @(posedge clk); #1;
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(31, 500, "restart");
    for (int k = 0; k < 10; k++) exp_mem[k] = 10;
    check_mem_a("restart");
  endtask

  task automatic test_addr_weights();
    set_act_all(2'b01);
    wmode = 1;
    set_btab_all(4'b0000);
    kick_a(1'b0);
    wait_done_a(1, 500, "addr_w");
    for (int k = 0; k < 10; k++) exp_mem[k] = 3 * k;
    check_mem_a("addr_w");
    wmode = 0;
  endtask

  task automatic test_bias_table();
    int vals [10];
    int exp_idx, exp_val;
    vals[0] = 3;  vals[1] = 7;  vals[2] = 7;  vals[3] = -2; vals[4] = 1;
    vals[5] = 0;  vals[6] = -5; vals[7] = 6;  vals[8] = 2;  vals[9] = -8;
    for (int k = 0; k < 10; k++) begin
      btab[k]    = 4'(vals[k]);
      exp_mem[k] = vals[k];
    end
    wconst = 2'b00;
    set_act_all(2'b01);
    kick_a(1'b0);
    wait_done_a(1, 500, "bias_tab");
    check_mem_a("bias_tab");
`ifdef DENSE_ARGMAX_EN
    exp_idx = 1; exp_val = 7;
`else
    exp_idx = 0; exp_val = 0;
`endif
    total++;
    if (max_idx_a !== 4'(exp_idx) || max_val_a !== 6'(exp_val)) begin
      bad++;
      $display("FAIL argmax: got idx=%0d val=%0d expected idx=%0d val=%0d",
               max_idx_a, $signed(max_val_a), exp_idx, exp_val);
    end
  endtask

  task automatic test_abort_start_same_cycle();
    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy_a !== 1'b0 || w_addr_a !== 9'd0) begin
      bad++;
      $display("FAIL abort_start: got busy=%b w_addr=%0d expected 0 0", busy_a, w_addr_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_lanes();
    int  cyc;
    bit  seen;
    relu_b  = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 2000) begin
      if (done_b === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!seen || cyc != 250 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL lanes2 done_cycle: got %0d busy=%b expected 250 busy=0", seen ? cyc : -1, busy_b);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      rd_addr_b = 4'(k);
      #1;
      total++;
      if (rd_data_b !== 6'(k - 5)) begin
        bad++;
        $display("FAIL lanes2 out[%0d]: got %0d expected %0d", k, $signed(rd_data_b), k - 5);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_saturate_pos();
    test_saturate_neg_relu();
    test_abort_restart();
    test_addr_weights();
    test_bias_table();
    test_abort_start_same_cycle();
    test_two_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
